// File: rtl/vga_timing_if.sv
// ---------------------------------------------------------------------------
// vga_timing_if
//   Bundles the run-enable input and the timing/coordinate outputs of
//   vga_timing.
//   Signals:
//     i_enable     : run enable. Low holds the generator idle.
//     o_pxlX       : framebuffer column 0..159, 0xFF outside the visible area
//     o_pxlY       : framebuffer row 0..119, 0xFF outside the visible area
//     o_hsync      : horizontal sync, active low, delayed by LAT
//     o_vsync      : vertical sync, active low, delayed by LAT
//     o_active     : visible-area flag, delayed by LAT
//     o_frameStart : one-cycle pulse at the start of vertical blank, delayed
//   Modports:
//     master : the controlling / consuming side (drives i_enable)
//     slave  : the timing generator itself
// ---------------------------------------------------------------------------
interface vga_timing_if;
  logic       i_enable;
  logic [7:0] o_pxlX;
  logic [7:0] o_pxlY;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_active;
  logic       o_frameStart;

  modport master (
    output i_enable,
    input  o_pxlX, o_pxlY, o_hsync, o_vsync, o_active, o_frameStart
  );

  modport slave (
    input  i_enable,
    output o_pxlX, o_pxlY, o_hsync, o_vsync, o_active, o_frameStart
  );
endinterface

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//   Pixel-clock timing generator for the 640x480@60 Hz display path.
//   Keeps horizontal/vertical position counters, presents the position
//   downscaled by 4 (160x120 framebuffer space) combinationally, and delays
//   sync/active/frame-start by LAT cycles so they line up with the colour
//   stage's registered framebuffer read.
//   Ports:
//     i_vga_clk : pixel clock (25 MHz nominal)
//     i_rst_n   : asynchronous active-low reset
//     bus       : vga_timing_if.slave (enable in, coordinates/syncs out)
//   LAT must be at least 1.
// ---------------------------------------------------------------------------
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int LAT       = 1
) (
  input  logic        i_vga_clk,
  input  logic        i_rst_n,
  vga_timing_if.slave bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // 10-bit versions of the boundaries so every compare is width-matched.
  localparam logic [9:0] H_VIS_C   = 10'(H_VISIBLE);
  localparam logic [9:0] H_SS_C    = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SE_C    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST_C  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS_C   = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS_C    = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SE_C    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST_C  = 10'(V_TOTAL - 1);

  // Pipeline word layout: {hsync, vsync, active, frameStart}.
  localparam logic [3:0] IDLE_WORD = 4'b1100;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       vis;
  logic       hs_raw;
  logic       vs_raw;
  logic       fs_raw;
  logic [3:0] stage_in;
  logic [3:0] pipe_q [LAT];
  logic [3:0] pipe_d [LAT];

  // Position counters. Disabling parks them at (0,0) so re-enable starts a
  // fresh frame on the very first enabled cycle.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!bus.i_enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST_C) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST_C) ? 10'd0 : v_cnt_q + 10'd1;
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge i_vga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Raw timing decode from the counter registers.
  always_comb begin
    vis    = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    hs_raw = !((h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C));
    vs_raw = !((v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C));
    fs_raw = (h_cnt_q == 10'd0) && (v_cnt_q == V_VIS_C);
  end

  // Coordinates leave undelayed: the downstream read register supplies the
  // one cycle that the sync pipeline below compensates for. 0xFF is out of
  // range downstream, so blanking reads as black.
  assign bus.o_pxlX = (bus.i_enable && vis) ? h_cnt_q[9:2] : 8'hFF;
  assign bus.o_pxlY = (bus.i_enable && vis) ? v_cnt_q[9:2] : 8'hFF;

  // Delay chain for the timing flags; idle word injected while disabled.
  always_comb begin
    stage_in = bus.i_enable ? {hs_raw, vs_raw, vis, fs_raw} : IDLE_WORD;
    pipe_d[0] = stage_in;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge i_vga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= IDLE_WORD;
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign bus.o_hsync      = pipe_q[LAT-1][3];
  assign bus.o_vsync      = pipe_q[LAT-1][2];
  assign bus.o_active     = pipe_q[LAT-1][1];
  assign bus.o_frameStart = pipe_q[LAT-1][0];

endmodule
